// File: rtl/axis_complex_power_peak_if.sv
// AXI-Stream bundle shared by the input (complex bins) and output (power) sides of
// axis_complex_power_peak.
//   tdata   payload, DataWidth bits
//   tvalid  beat valid (master -> slave)
//   tready  beat accepted when tvalid && tready (slave -> master)
//   tlast   last beat of a frame (master -> slave)
interface axis_complex_power_peak_if #(
  parameter int unsigned DataWidth = 32
) ();
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_complex_power_peak.sv
// Per-bin power |z|^2 = re^2 + im^2 of averaged complex spectrum frames, plus a per-frame
// peak-bin report for the PS.
//   aclk         clock
//   areset       asynchronous reset, active high
//   S_AXIS       input stream, tdata = {real, imag}, signed halves, tlast on last bin
//   M_AXIS       output stream, tdata = unsigned power, tlast delayed with its beat
//   peak_index   bin index of the largest power in the last completed frame
//   peak_power   power of that bin
//   peak_strobe  one-cycle pulse when peak_index/peak_power update
//   frame_count  completed frames, wraps modulo 2^16
module axis_complex_power_peak #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned POWER_WIDTH      = 32,
  parameter int unsigned INDEX_WIDTH      = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  axis_complex_power_peak_if.slave       S_AXIS,
  axis_complex_power_peak_if.master      M_AXIS,
  output logic [INDEX_WIDTH-1:0]         peak_index,
  output logic [POWER_WIDTH-1:0]         peak_power,
  output logic                           peak_strobe,
  output logic [15:0]                    frame_count
);

  localparam int unsigned HalfW = AXIS_TDATA_WIDTH / 2;
  localparam int unsigned SqW   = AXIS_TDATA_WIDTH - 1;

  // Pipeline state
  logic                        rdy_q;
  logic                        s1_valid_q, s1_last_q;
  logic signed [HalfW-1:0]     s1_re_q, s1_im_q;
  logic                        s2_valid_q, s2_last_q;
  logic [SqW-1:0]              s2_re_sq_q, s2_im_sq_q;
  logic                        s3_valid_q, s3_last_q;
  logic [POWER_WIDTH-1:0]      s3_power_q;

  // Tracker state
  logic [INDEX_WIDTH-1:0]      bin_cnt_q;
  logic [POWER_WIDTH-1:0]      cur_max_q;
  logic [INDEX_WIDTH-1:0]      cur_idx_q;
  logic [INDEX_WIDTH-1:0]      peak_index_q;
  logic [POWER_WIDTH-1:0]      peak_power_q;
  logic                        peak_strobe_q;
  logic [15:0]                 frame_count_q;

  logic                        ce;
  logic                        in_ready;
  logic                        m_hs;
  logic                        take;
  logic [POWER_WIDTH-1:0]      fin_max;
  logic [INDEX_WIDTH-1:0]      fin_idx;
  logic signed [AXIS_TDATA_WIDTH-1:0] re_prod, im_prod;
  logic [AXIS_TDATA_WIDTH-1:0] sum;
  logic                        unused_prod_msbs;

  // Whole pipeline advances together; a full S3 facing a stalled sink freezes everything.
  assign ce       = ~s3_valid_q | M_AXIS.tready;
  // rdy_q keeps tready low during reset and raises it on the first edge after release.
  assign in_ready = ce & rdy_q;
  assign S_AXIS.tready = in_ready;

  // Full-width signed squares; the sign bit of a square is always 0, so SqW bits are exact.
  assign re_prod = s1_re_q * s1_re_q;
  assign im_prod = s1_im_q * s1_im_q;
  assign unused_prod_msbs = re_prod[AXIS_TDATA_WIDTH-1] ^ im_prod[AXIS_TDATA_WIDTH-1];
  // One extra bit holds the carry: (-2^15)^2 * 2 = 2^31.
  assign sum = {1'b0, s2_re_sq_q} + {1'b0, s2_im_sq_q};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_re_sq_q <= '0;
      s2_im_sq_q <= '0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_power_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (ce) begin
        s1_valid_q <= S_AXIS.tvalid & in_ready;
        s1_last_q  <= S_AXIS.tlast;
        s1_re_q    <= S_AXIS.tdata[AXIS_TDATA_WIDTH-1:HalfW];
        s1_im_q    <= S_AXIS.tdata[HalfW-1:0];
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
        s2_re_sq_q <= re_prod[SqW-1:0];
        s2_im_sq_q <= im_prod[SqW-1:0];
        s3_valid_q <= s2_valid_q;
        s3_last_q  <= s2_last_q;
        s3_power_q <= POWER_WIDTH'(sum);
      end
    end
  end

  assign M_AXIS.tvalid = s3_valid_q;
  assign M_AXIS.tlast  = s3_last_q;
  assign M_AXIS.tdata  = s3_power_q;

  // Peak of the frame including the beat currently handshaken. Index 0 loads
  // unconditionally; afterwards only a strictly larger power wins, so ties keep the earliest.
  always_comb begin
    m_hs    = s3_valid_q & M_AXIS.tready;
    take    = (bin_cnt_q == '0) | (s3_power_q > cur_max_q);
    fin_max = take ? s3_power_q : cur_max_q;
    fin_idx = take ? bin_cnt_q : cur_idx_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bin_cnt_q     <= '0;
      cur_max_q     <= '0;
      cur_idx_q     <= '0;
      peak_index_q  <= '0;
      peak_power_q  <= '0;
      peak_strobe_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      peak_strobe_q <= 1'b0;
      if (m_hs) begin
        cur_max_q <= fin_max;
        cur_idx_q <= fin_idx;
        if (s3_last_q) begin
          bin_cnt_q     <= '0;
          peak_index_q  <= fin_idx;
          peak_power_q  <= fin_max;
          peak_strobe_q <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
        end else begin
          bin_cnt_q <= bin_cnt_q + INDEX_WIDTH'(1);
        end
      end
    end
  end

  assign peak_index  = peak_index_q;
  assign peak_power  = peak_power_q;
  assign peak_strobe = peak_strobe_q;
  assign frame_count = frame_count_q;

endmodule
